// File: rtl/wmem_readback.sv
// Weight-memory readback engine: walks rows [h_first, h_first+h_count) of one
// layer and streams every weight over AXI-Stream through a 2-entry FIFO.
module wmem_readback #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 512,
    parameter int N_HIDDEN = 256,
    parameter int N_LAYERS = 7,
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
    localparam int HW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1,
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LW-1:0]            cfg_layer,
    input  logic [HW-1:0]            cfg_h_first,
    input  logic [HW:0]              cfg_h_count,
    output logic                     rd_en,
    output logic [LW-1:0]            rd_addr_l,
    output logic [HW-1:0]            rd_addr_h,
    output logic [IW-1:0]            rd_addr_i,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic signed [DATA_W-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    // Row counters carry one extra bit so h_first + h_count = N_HIDDEN never wraps.
    logic [LW-1:0] layer_q;
    logic [HW:0]   h_q;
    logic [HW:0]   h_end_q;
    logic [IW-1:0] i_q;

    logic inflight_q;
    logic inflight_last_q;
    logic cfg_err_q;

    logic signed [DATA_W-1:0] fifo_data [2];
    logic                     fifo_last [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;

    logic          cfg_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          issue;
    logic          row_end;
    logic          last_read;
    logic          final_pop;
    logic [HW+1:0] h_span;
    logic [2:0]    room_used;

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        h_span    = {2'b00, cfg_h_first} + {1'b0, cfg_h_count};
        cfg_ok    = ({1'b0, cfg_layer} < (LW+1)'(N_LAYERS))
                    && (cfg_h_count != '0)
                    && (h_span <= (HW+2)'(N_HIDDEN));
        accept    = (state == IDLE) && start && cfg_ok;
        push      = inflight_q;
        pop       = (count != 2'd0) && m_axis_tready;
        // The head word leaving this cycle frees its slot for a read issued now,
        // which is what lets the stream sustain one beat per cycle.
        room_used = {1'b0, count} - {2'b00, pop} + {2'b00, inflight_q};
        issue     = (state == READ) && (room_used < 3'd2);
        row_end   = (i_q == IW'(N_IN - 1));
        last_read = row_end && ((h_q + (HW+1)'(1)) == h_end_q);
        final_pop = (state == DRAIN) && pop && (count == 2'd1) && !inflight_q;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)              state_next = READ;
            READ:    if (issue && last_read)  state_next = DRAIN;
            DRAIN:   if (final_pop)           state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            layer_q         <= '0;
            h_q             <= '0;
            h_end_q         <= '0;
            i_q             <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cfg_err_q       <= 1'b0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            count           <= 2'd0;
        end else begin
            state     <= state_next;
            cfg_err_q <= (state == IDLE) && start && !cfg_ok;

            if (accept) begin
                layer_q <= cfg_layer;
                h_q     <= {1'b0, cfg_h_first};
                h_end_q <= h_span[HW:0];
                i_q     <= '0;
            end else if (issue) begin
                if (row_end) begin
                    i_q <= '0;
                    h_q <= h_q + (HW+1)'(1);
                end else begin
                    i_q <= i_q + IW'(1);
                end
            end

            inflight_q      <= issue;
            inflight_last_q <= row_end;

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: FIFO storage is deliberately not reset; occupancy and pointers are, and
    // the output mux hides any entry that has not been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_last[wr_ptr] <= inflight_last_q;
        end
    end

    assign rd_en         = issue && !rst;
    assign rd_addr_l     = rst ? '0 : layer_q;
    assign rd_addr_h     = rst ? '0 : h_q[HW-1:0];
    assign rd_addr_i     = rst ? '0 : i_q;

    assign m_axis_tvalid = (count != 2'd0) && !rst;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];

    assign busy          = (state != IDLE) && !rst;
    assign done          = final_pop && !rst;
    assign cfg_err       = cfg_err_q && !rst;

endmodule

// File: tb/tb_wmem_readback.sv
// Self-checking bench for wmem_readback: a queue-based model of the expected
// stream and handshake rules, plus directed literal streams and random traffic.
module tb_wmem_readback;

    localparam int DATA_W   = 16;
    localparam int N_IN     = 4;
    localparam int N_HIDDEN = 4;
    localparam int N_LAYERS = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [0:0]               cfg_layer = '0;
    logic [1:0]               cfg_h_first = '0;
    logic [2:0]               cfg_h_count = '0;
    logic                     rd_en;
    logic [0:0]               rd_addr_l;
    logic [1:0]               rd_addr_h;
    logic [1:0]               rd_addr_i;
    logic signed [DATA_W-1:0] rd_data = '0;
    logic signed [DATA_W-1:0] m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready = 1'b1;
    logic                     m_axis_tlast;
    logic                     busy;
    logic                     done;
    logic                     cfg_err;

    // Second instance with three layers: the only way to present an out-of-range
    // layer index, since a 2-layer block has a 1-bit layer field.
    logic                     l3_start = 1'b0;
    logic [1:0]               l3_layer = '0;
    logic [1:0]               l3_hf = '0;
    logic [2:0]               l3_hc = '0;
    logic signed [DATA_W-1:0] l3_rd_data = '0;
    logic                     l3_rd_en;
    logic [1:0]               l3_addr_l;
    logic [1:0]               l3_addr_h;
    logic [1:0]               l3_addr_i;
    logic signed [DATA_W-1:0] l3_tdata;
    logic                     l3_tvalid;
    logic                     l3_tlast;
    logic                     l3_busy;
    logic                     l3_done;
    logic                     l3_err;

    wmem_readback #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(N_LAYERS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_layer(cfg_layer), .cfg_h_first(cfg_h_first), .cfg_h_count(cfg_h_count),
        .rd_en(rd_en), .rd_addr_l(rd_addr_l), .rd_addr_h(rd_addr_h), .rd_addr_i(rd_addr_i),
        .rd_data(rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    wmem_readback #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(3)) dut_l3 (
        .clk(clk), .rst(rst), .start(l3_start),
        .cfg_layer(l3_layer), .cfg_h_first(l3_hf), .cfg_h_count(l3_hc),
        .rd_en(l3_rd_en), .rd_addr_l(l3_addr_l), .rd_addr_h(l3_addr_h), .rd_addr_i(l3_addr_i),
        .rd_data(l3_rd_data),
        .m_axis_tdata(l3_tdata), .m_axis_tvalid(l3_tvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(l3_tlast),
        .busy(l3_busy), .done(l3_done), .cfg_err(l3_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic signed [DATA_W-1:0] word(input int l, input int h, input int i);
        return DATA_W'(l * 100 + h * 10 + i);
    endfunction

    // Memory with 1-cycle latency; junk on idle cycles exposes stray captures.
    always @(posedge clk)
        rd_data <= rd_en ? word(int'(rd_addr_l), int'(rd_addr_h), int'(rd_addr_i))
                         : DATA_W'($urandom);

    bit bp = 1'b0;
    always @(posedge clk) begin
        #1;
        m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct {
        int data;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    got_q[$];
    bit    got_last[$];
    int    got_cyc[$];
    bit    busy_exp = 1'b0;
    bit    err_exp = 1'b0;
    int    outstanding = 0;
    bit    prev_stall = 1'b0;
    int    prev_data = 0;
    bit    prev_last = 1'b0;
    bit    lat_pending = 1'b0;
    int    lat_start = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    rd_cnt = 0;

    always @(negedge clk) begin
        bit    acc;
        bit    final_beat;
        bit    busy_next;
        beat_t e;
        int    l, hf, hc;
        cyc++;
        if (rst) begin
            check("rst_rd_en", rd_en, 0);
            check("rst_tvalid", m_axis_tvalid, 0);
            check("rst_tlast", m_axis_tlast, 0);
            check("rst_tdata", m_axis_tdata, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_cfg_err", cfg_err, 0);
            check("rst_addr", {rd_addr_l, rd_addr_h, rd_addr_i}, 0);
            exp_q.delete();
            busy_exp    = 1'b0;
            err_exp     = 1'b0;
            outstanding = 0;
            prev_stall  = 1'b0;
            lat_pending = 1'b0;
        end else begin
            acc        = m_axis_tvalid && m_axis_tready;
            final_beat = 1'b0;
            busy_next  = busy_exp;
            check("busy", busy, busy_exp);
            check("cfg_err", cfg_err, err_exp);
            if (!busy_exp) check("rd_en_idle", rd_en, 0);
            // Words read but not yet accepted may never exceed the two FIFO slots.
            if (rd_en) check("fifo_room", (outstanding - int'(acc)) < 2, 1);
            if (prev_stall) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && lat_pending) begin
                check("first_tvalid_latency", (cyc - lat_start) <= 3, 1);
                lat_pending = 1'b0;
            end
            if (acc) begin
                if (exp_q.size() == 0) begin
                    check("beat_expected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tlast", m_axis_tlast, e.last);
                    got_q.push_back(int'(m_axis_tdata));
                    got_last.push_back(m_axis_tlast);
                    got_cyc.push_back(cyc);
                    final_beat = (exp_q.size() == 0);
                end
            end
            check("done", done, final_beat);
            if (done) done_cnt++;
            if (rd_en) rd_cnt++;
            outstanding += int'(rd_en) - int'(acc);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = int'(m_axis_tdata);
            prev_last  = m_axis_tlast;

            err_exp = 1'b0;
            if (start && !busy_exp) begin
                l  = int'(cfg_layer);
                hf = int'(cfg_h_first);
                hc = int'(cfg_h_count);
                if (l < N_LAYERS && hc != 0 && hf + hc <= N_HIDDEN) begin
                    for (int h = hf; h < hf + hc; h++)
                        for (int i = 0; i < N_IN; i++)
                            exp_q.push_back('{data: int'(word(l, h, i)), last: (i == N_IN - 1)});
                    busy_next   = 1'b1;
                    lat_pending = 1'b1;
                    lat_start   = cyc;
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (final_beat) busy_next = 1'b0;
            busy_exp = busy_next;
        end
    end

    task automatic do_start(input int l, input int hf, input int hc);
        @(posedge clk);
        #1;
        cfg_layer   = 1'(l);
        cfg_h_first = 2'(hf);
        cfg_h_count = 3'(hc);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (!busy_exp && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0;
    endtask

    int lit[8];

    task automatic check_stream(input string name, input int n);
        check({name, "_len"}, got_q.size(), n);
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            check({name, "_word"}, got_q[k], lit[k]);
            check({name, "_last"}, got_last[k], (k % 4) == 3);
        end
        check({name, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

    initial begin
        int rc0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_tvalid", m_axis_tvalid, 0);

        // Full-rate readback.
        clear_log();
        do_start(1, 2, 2);
        wait_idle("s037");
        lit = '{120, 121, 122, 123, 130, 131, 132, 133};
        check_stream("s037", 8);
        if (got_cyc.size() == 8) check("s037_consecutive", got_cyc[7] - got_cyc[0], 7);
        @(negedge clk);
        check("s037_busy_after", busy, 0);

        // Same transfer under random backpressure.
        clear_log();
        bp = 1'b1;
        do_start(1, 2, 2);
        wait_idle("s038");
        check_stream("s038", 8);
        bp = 1'b0;

        // Invalid configurations.
        rc0 = rd_cnt;
        do_start(0, 0, 0);
        @(negedge clk);
        check("s039_cnt0_err", cfg_err, 1);
        check("s039_cnt0_busy", busy, 0);
        do_start(0, 3, 2);
        @(negedge clk);
        check("s039_span_err", cfg_err, 1);
        check("s039_span_busy", busy, 0);
        @(negedge clk);
        check("s039_err_pulse", cfg_err, 0);
        check("s039_no_reads", rd_cnt, rc0);
        @(posedge clk);
        #1;
        l3_layer = 2'd3; l3_hf = 2'd0; l3_hc = 3'd1; l3_start = 1'b1;
        @(posedge clk);
        #1;
        l3_start = 1'b0;
        @(negedge clk);
        check("s039_layer_err", l3_err, 1);
        check("s039_layer_busy", l3_busy, 0);
        check("s039_layer_rd", l3_rd_en, 0);
        @(negedge clk);
        check("s039_layer_pulse", l3_err, 0);
        check("s039_layer_rd2", l3_rd_en, 0);

        // Start while busy is ignored.
        clear_log();
        do_start(0, 1, 2);
        repeat (2) @(posedge clk);
        do_start(1, 0, 3);
        wait_idle("s040");
        lit = '{10, 11, 12, 13, 20, 21, 22, 23};
        check_stream("s040", 8);

        // Reset mid-stream, then restart in the first cycle out of reset.
        clear_log();
        do_start(1, 0, 2);
        for (int k = 0; k < 100 && got_q.size() < 3; k++) begin
            @(negedge clk);
            #1;
        end
        check("s041_three_beats", got_q.size(), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("s041_rst_tvalid", m_axis_tvalid, 0);
        check("s041_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_layer = 1'b0; cfg_h_first = 2'd0; cfg_h_count = 3'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("s041_no_done", done_cnt, 0);
        clear_log();
        wait_idle("s041");
        lit = '{0, 1, 2, 3, 0, 0, 0, 0};
        check_stream("s041", 4);

        // Last row of the array.
        clear_log();
        do_start(0, 3, 1);
        wait_idle("s042");
        lit = '{30, 31, 32, 33, 0, 0, 0, 0};
        check_stream("s042", 4);
        @(negedge clk);
        check("s042_busy_after", busy, 0);

        // Random traffic against the model.
        for (int n = 0; n < 30; n++) begin
            bp = 1'($urandom_range(0, 1));
            do_start($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                do_start($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 5));
            end
            wait_idle("rand");
        end
        bp = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wmem_readback.md
WMEM_READBACK -- requirements
Module: wmem_readback

Interface
REQ-001 Parameter DATA_W, default 16, width of one weight word.
REQ-002 Parameter N_IN, default 512, weights per hidden-neuron row.
REQ-003 Parameter N_HIDDEN, default 256, rows per layer.
REQ-004 Parameter N_LAYERS, default 7, layers held in weight memory.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  one-cycle request to begin a readback.
REQ-008 cfg_layer  in  $clog2(N_LAYERS)  layer to read; sampled when start is accepted.
REQ-009 cfg_h_first  in  $clog2(N_HIDDEN)  first row to read; sampled when start is accepted.
REQ-010 cfg_h_count  in  $clog2(N_HIDDEN)+1  number of rows to read; sampled when start is accepted.
REQ-011 rd_en  out  1  weight memory read strobe.
REQ-012 rd_addr_l / rd_addr_h / rd_addr_i  out  $clog2(N_LAYERS) / $clog2(N_HIDDEN) / $clog2(N_IN)  read address.
REQ-013 rd_data  in  DATA_W signed  read data, valid exactly 1 cycle after rd_en.
REQ-014 m_axis_tdata  out  DATA_W signed  weight word.
REQ-015 m_axis_tvalid / m_axis_tready  out / in  1  AXI-Stream handshake.
REQ-016 m_axis_tlast  out  1  marks the final word (i = N_IN-1) of each row.
REQ-017 busy  out  1  high from accepted start until done.
REQ-018 done  out  1  one-cycle pulse after the final beat is accepted.
REQ-019 cfg_err  out  1  one-cycle pulse when start is rejected for invalid configuration.

Function
REQ-020 The block SHALL implement states IDLE, READ and DRAIN.
REQ-021 IDLE->READ SHALL occur on start with a valid config; busy SHALL rise in the following cycle.
REQ-022 A config is invalid when cfg_layer >= N_LAYERS, cfg_h_count = 0, or cfg_h_first + cfg_h_count > N_HIDDEN; on an invalid config the block SHALL pulse cfg_err in the next cycle and remain in IDLE.
REQ-023 start SHALL be ignored while busy, with no effect on counters or cfg_err.
REQ-024 Read addresses SHALL iterate i from 0 to N_IN-1 (innermost), then h from cfg_h_first to cfg_h_first+cfg_h_count-1, with l held at cfg_layer.
REQ-025 Output words SHALL be buffered in a 2-entry FIFO; rd_en SHALL assert only when (FIFO occupancy + reads in flight) < 2, so no word is ever dropped under backpressure.
REQ-026 With m_axis_tready held high, the block SHALL sustain one beat per cycle; the first tvalid SHALL assert no later than 3 cycles after start.
REQ-027 Each beat's tlast SHALL travel with its word through the FIFO and be high only when that word's i = N_IN-1.
REQ-028 Once asserted, tvalid, tdata and tlast SHALL hold stable until the beat is accepted (tvalid and tready both high).
REQ-029 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-030 READ->DRAIN SHALL occur when the final read is issued; DRAIN->IDLE SHALL occur on acceptance of the final beat, with done pulsing in that same cycle and busy low in the next cycle.
REQ-031 Row and column counters SHALL be wide enough for cfg_h_first + cfg_h_count = N_HIDDEN without wrap-around.
REQ-032 tdata SHALL be rd_data unmodified (no sign extension or truncation).

Reset
REQ-033 While rst is high, the block SHALL force state IDLE and flush the FIFO and in-flight tracking.
REQ-034 While rst is high, rd_en, m_axis_tvalid, m_axis_tlast, busy, done and cfg_err SHALL be 0.
REQ-035 While rst is high, m_axis_tdata and the rd_addr fields SHALL be 0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the block SHALL accept a new start in the first cycle after rst deasserts.

Verification
Bench setup: N_IN=4, N_HIDDEN=4, N_LAYERS=2; memory model preloaded with word = l*100 + h*10 + i, 1-cycle read latency.
REQ-037 Full-rate readback: tready=1, start with layer=1, h_first=2, h_count=2 -> stream 120,121,122,123(tlast),130,131,132,133(tlast); 8 consecutive beats; one done pulse.
REQ-038 Backpressure: same transfer with tready toggling randomly -> identical 8-word order; tdata stable while stalled; no rd_en issued while occupancy + in-flight = 2.
REQ-039 Invalid configs: (layer=2), (h_count=0) and (h_first=3, h_count=2) -> cfg_err pulse for each; no rd_en; busy stays 0.
REQ-040 Start while busy: second start pulsed mid-transfer with different config -> first transfer's stream unchanged; exactly one done pulse.
REQ-041 Reset mid-stream: rst asserted after 3 accepted beats -> tvalid/busy = 0 the next cycle; no done; a new start with layer=0, h_first=0, h_count=1 -> stream 0,1,2,3(tlast).
REQ-042 Row boundary: layer=0, h_first=3, h_count=1 -> stream 30,31,32,33(tlast) with no counter wrap; done pulse; busy low in the next cycle.
